// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM controller for a 16-bit ISA driving the ALU, register file, memory and PC.
// Memory stalls hold FETCH/MEM until mem_ack; reset forces every output low and restarts in FETCH.
module control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        mem_ack,
    input  logic        c_in,
    input  logic        l_in,
    input  logic        f_in,
    input  logic        z_in,
    input  logic        n_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [3:0]  alu_control,
    output logic        imm_sel,
    output logic        imm_sext,
    output logic        b_zero,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [7:0]  imm,
    output logic        pc_en,
    output logic [1:0]  pc_src
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_MEM    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    logic [3:0]  op;
    logic [3:0]  ext;
    logic [3:0]  cond;
    logic [3:0]  alu_key;
    logic        is_rtype;
    logic        is_itype;
    logic        is_load;
    logic        is_stor;
    logic        is_jcond;
    logic        is_bcond;
    logic        cond_true;

    // The N flag is part of the ALU flag bus but no condition code tests it.
    logic        unused_flags;
    assign unused_flags = n_in;

    function automatic logic is_alu_code(input logic [3:0] k);
        case (k)
            4'b0101, 4'b1001, 4'b1011, 4'b0001,
            4'b0010, 4'b0011, 4'b1101: is_alu_code = 1'b1;
            default:                   is_alu_code = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] k);
        case (k)
            4'b0101: alu_code = 4'b1000;
            4'b1001: alu_code = 4'b0001;
            4'b1011: alu_code = 4'b0010;
            4'b0001: alu_code = 4'b0011;
            4'b0010: alu_code = 4'b0100;
            4'b0011: alu_code = 4'b0101;
            4'b1111: alu_code = 4'b0110;
            4'b1101: alu_code = 4'b0100;
            default: alu_code = 4'b0000;
        endcase
    endfunction

    assign op       = ir[15:12];
    assign ext      = ir[7:4];
    assign cond     = ir[11:8];
    assign is_rtype = (op == 4'b0000) && is_alu_code(ext);
    assign is_itype = is_alu_code(op) || (op == 4'b1111);
    assign is_load  = (op == 4'b0100) && (ext == 4'b0000);
    assign is_stor  = (op == 4'b0100) && (ext == 4'b0100);
    assign is_jcond = (op == 4'b0100) && (ext == 4'b1100);
    assign is_bcond = (op == 4'b1100);
    // R-type carries its ALU operation in the ext field, I-type in the opcode.
    assign alu_key  = is_rtype ? ext : op;

    always_comb begin
        case (cond)
            4'b0000: cond_true = z_in;
            4'b0001: cond_true = ~z_in;
            4'b0010: cond_true = c_in;
            4'b0011: cond_true = ~c_in;
            4'b0100: cond_true = l_in;
            4'b0101: cond_true = ~l_in;
            4'b0110: cond_true = f_in;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ack) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        alu_control = 4'b0000;
        imm_sel     = 1'b0;
        imm_sext    = 1'b0;
        b_zero      = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        rdest       = ir[11:8];
        rsrc        = ir[3:0];
        imm         = ir[7:0];

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_rtype || is_itype) begin
                    state_nxt = S_EXEC;
                end else if (is_load || is_stor) begin
                    state_nxt = S_MEM;
                end else begin
                    pc_en     = 1'b1;
                    state_nxt = S_FETCH;
                    if (is_bcond && cond_true) begin
                        pc_src = 2'b10;
                    end else if (is_jcond && cond_true) begin
                        pc_src = 2'b11;
                    end else begin
                        pc_src = 2'b01;
                    end
                end
            end
            S_EXEC: begin
                alu_control = alu_code(alu_key);
                b_zero      = (alu_key == 4'b1101);
                imm_sel     = is_itype;
                imm_sext    = is_itype && ((op == 4'b0101) || (op == 4'b1001) ||
                                           (op == 4'b1011) || (op == 4'b1101));
                rf_we       = (alu_key != 4'b1011);
                pc_en       = 1'b1;
                pc_src      = 2'b01;
                state_nxt   = S_FETCH;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_stor;
                if (mem_ack) begin
                    rf_we     = is_load;
                    wb_sel    = is_load;
                    pc_en     = 1'b1;
                    pc_src    = 2'b01;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase

        // Outputs are held low for the whole reset cycle, whatever state was left behind.
        if (reset) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            alu_control = 4'b0000;
            imm_sel     = 1'b0;
            imm_sext    = 1'b0;
            b_zero      = 1'b0;
            rf_we       = 1'b0;
            wb_sel      = 1'b0;
            pc_en       = 1'b0;
            pc_src      = 2'b00;
            rdest       = 4'h0;
            rsrc        = 4'h0;
            imm         = 8'h00;
        end
    end

endmodule
